// File: rtl/irq_pkg.sv
// Shared types for the interrupt source unit: channel state and default line count.
package irq_pkg;
  localparam int IRQ_NUM_DEF = 16;

  typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_ch_state_t;

  typedef logic [IRQ_NUM_DEF-1:0] irq_vec_t;
endpackage

// File: rtl/irq_channel.sv
// One request line: event synchroniser, rising-edge detect, IDLE/PEND FSM,
// saturating coalesce counter and sticky overflow flag.
module irq_channel
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_raw,
  input  logic             edge_mode,
  input  logic             ret,
  input  logic             clr,
  output logic             req,
  output logic             ovf,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic          evt_s;
  logic          evt_d;
  logic          rise;
  irq_ch_state_t state;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign evt_s = evt_raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES:0]   sync_nxt;

      assign sync_nxt = {sync_q, evt_raw};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_nxt[SYNC_STAGES-1:0];
        end
      end

      assign evt_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // evt_d resets low so a line already high at reset release reads as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_d <= 1'b0;
    end else begin
      evt_d <= evt_s;
    end
  end

  assign rise = evt_s & ~evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IRQ_IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= IRQ_IDLE;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (edge_mode) begin
      case (state)
        IRQ_IDLE: begin
          if (rise) begin
            state <= IRQ_PEND;
          end
        end
        IRQ_PEND: begin
          if (ret) begin
            // A rise coinciding with the return replaces the delivery just consumed.
            if (cnt != '0) begin
              if (!rise) begin
                cnt <= cnt - CNT_ONE;
              end
            end else if (!rise) begin
              state <= IRQ_IDLE;
            end
          end else if (rise) begin
            if (cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: state <= IRQ_IDLE;
      endcase
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (evt_s) begin
            state <= IRQ_PEND;
          end
        end
        IRQ_PEND: begin
          if (ret) begin
            state <= IRQ_IDLE;
          end
        end
        default: state <= IRQ_IDLE;
      endcase
    end
  end

  assign req = (state == IRQ_PEND);

endmodule

// File: rtl/irq_source_unit.sv
// Peripheral-side interrupt request generator: one irq_channel per line plus
// a combinational readback mux for the per-line coalesce counters.
module irq_source_unit
  import irq_pkg::*;
#(
  parameter int IRQ_NUM     = IRQ_NUM_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [IRQ_NUM-1:0]         event_i,
  input  logic [IRQ_NUM-1:0]         edge_mode_i,
  input  logic [IRQ_NUM-1:0]         irq_ret_i,
  input  logic [IRQ_NUM-1:0]         clr_i,
  output logic [IRQ_NUM-1:0]         irq_req_o,
  output logic [IRQ_NUM-1:0]         ovf_o,
  input  logic [$clog2(IRQ_NUM)-1:0] cnt_sel_i,
  output logic [CNT_W-1:0]           cnt_o
);

  logic [CNT_W-1:0] cnt_arr [IRQ_NUM];

  generate
    for (genvar k = 0; k < IRQ_NUM; k++) begin : g_ch
      irq_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
      ) u_ch (
        .clk      (clk_i),
        .rst      (rst_i),
        .evt_raw  (event_i[k]),
        .edge_mode(edge_mode_i[k]),
        .ret      (irq_ret_i[k]),
        .clr      (clr_i[k]),
        .req      (irq_req_o[k]),
        .ovf      (ovf_o[k]),
        .cnt      (cnt_arr[k])
      );
    end
  endgenerate

  assign cnt_o = cnt_arr[cnt_sel_i];

endmodule

// File: tb/tb_irq_source_unit.sv
// Randomised and directed stimulus for irq_source_unit, checked by a scoreboard
// fed from a per-line behavioural model of the request/return protocol.
module tb_irq_source_unit;
  import irq_pkg::*;

  localparam int N  = 16;
  localparam int CW = 4;
  localparam int SS = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  irq_vec_t      event_i, edge_mode_i, irq_ret_i, clr_i;
  irq_vec_t      irq_req_o, ovf_o;
  logic [3:0]    cnt_sel_i;
  logic [CW-1:0] cnt_o;

  irq_source_unit #(.IRQ_NUM(N), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .event_i    (event_i),
    .edge_mode_i(edge_mode_i),
    .irq_ret_i  (irq_ret_i),
    .clr_i      (clr_i),
    .irq_req_o  (irq_req_o),
    .ovf_o      (ovf_o),
    .cnt_sel_i  (cnt_sel_i),
    .cnt_o      (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned tag;
    irq_vec_t    req;
    irq_vec_t    ovf;
    int          cnt;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Reference model: per-line pending flag, backlog count, overflow flag,
  // and a history of driven event vectors standing in for the synchroniser.
  bit       m_pend[N];
  int       m_cnt[N];
  bit       m_ovf[N];
  irq_vec_t evq[$];

  irq_vec_t   mode_v;
  irq_vec_t   lvl_v;
  logic [3:0] sel_v;

  function automatic irq_vec_t bitv(int k);
    irq_vec_t v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_cnt[k]  = 0;
      m_ovf[k]  = 1'b0;
    end
    evq.delete();
    for (int i = 0; i <= SS; i++) evq.push_back('0);
    sbq.delete();
  endtask

  task automatic model_step(irq_vec_t ev, irq_vec_t mode, irq_vec_t ret, irq_vec_t clr,
                            logic [3:0] sel);
    irq_vec_t s, d, rise;
    exp_t     e;
    evq.push_back(ev);
    s = evq[evq.size()-1-SS];
    d = evq[evq.size()-2-SS];
    if (evq.size() > 8) void'(evq.pop_front());
    rise = s & ~d;
    for (int k = 0; k < N; k++) begin
      if (clr[k]) begin
        m_pend[k] = 1'b0;
        m_cnt[k]  = 0;
        m_ovf[k]  = 1'b0;
      end else if (mode[k]) begin
        if (!m_pend[k]) begin
          if (rise[k]) m_pend[k] = 1'b1;
        end else if (ret[k]) begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1 + int'(rise[k]);
          else if (!rise[k]) m_pend[k] = 1'b0;
        end else if (rise[k]) begin
          if (m_cnt[k] == CMAX) m_ovf[k] = 1'b1;
          else m_cnt[k]++;
        end
      end else begin
        if (!m_pend[k]) begin
          if (s[k]) m_pend[k] = 1'b1;
        end else if (ret[k]) begin
          m_pend[k] = 1'b0;
        end
      end
    end
    e.tag = cyc + 1;
    for (int k = 0; k < N; k++) begin
      e.req[k] = m_pend[k];
      e.ovf[k] = m_ovf[k];
    end
    e.cnt = m_cnt[sel];
    sbq.push_back(e);
  endtask

  task automatic drive(irq_vec_t ev, irq_vec_t ret, irq_vec_t clr);
    @(negedge clk_i);
    event_i     = ev | lvl_v;
    edge_mode_i = mode_v;
    irq_ret_i   = ret;
    clr_i       = clr;
    cnt_sel_i   = sel_v;
    model_step(ev | lvl_v, mode_v, ret, clr, sel_v);
  endtask

  task automatic idle(int n);
    repeat (n) drive('0, '0, '0);
  endtask

  task automatic pulse(irq_vec_t v, int n);
    repeat (n) begin
      drive(v, '0, '0);
      drive('0, '0, '0);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: compares each registered state update one step after the edge.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
      e = sbq.pop_front();
      if (e.tag != cyc) begin
        chk("sb_stale_tag", e.tag, cyc);
      end else begin
        chk("irq_req", 32'(irq_req_o), 32'(e.req));
        chk("ovf", 32'(ovf_o), 32'(e.ovf));
        chk("cnt", 32'(cnt_o), e.cnt);
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    event_i     = '0;
    irq_ret_i   = '0;
    clr_i       = '0;
    mode_v      = '1;
    lvl_v       = '0;
    sel_v       = 4'd0;
    edge_mode_i = mode_v;
    cnt_sel_i   = sel_v;
    model_reset();

    #7;
    chk("reset_req", 32'(irq_req_o), 0);
    chk("reset_ovf", 32'(ovf_o), 0);
    chk("reset_cnt", 32'(cnt_o), 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Edge pulse on line 3, then return it.
    sel_v = 4'd3;
    drive(bitv(3), '0, '0);
    idle(4);
    drive('0, bitv(3), '0);
    idle(2);

    // Coalesce three extra edges on line 5, drain them one return at a time.
    sel_v = 4'd5;
    pulse(bitv(5), 4);
    idle(3);
    repeat (4) begin
      drive('0, bitv(5), '0);
      idle(1);
    end
    idle(2);

    // Saturate line 0 and clear it.
    sel_v = 4'd0;
    pulse(bitv(0), 17);
    idle(3);
    drive('0, '0, bitv(0));
    idle(2);

    // Level line 7: one-cycle gap on return while held, then drop and return.
    sel_v     = 4'd7;
    mode_v[7] = 1'b0;
    lvl_v     = bitv(7);
    idle(4);
    drive('0, bitv(7), '0);
    idle(4);
    lvl_v = '0;
    idle(4);
    drive('0, bitv(7), '0);
    idle(4);
    mode_v[7] = 1'b1;
    idle(3);

    // Line 2 at cnt 0: rise and return in the same cycle; return on idle line 9.
    sel_v = 4'd2;
    pulse(bitv(2), 1);
    idle(3);
    drive(bitv(2), '0, '0);
    drive('0, '0, '0);
    drive('0, bitv(2), '0);
    idle(3);
    sel_v = 4'd9;
    drive('0, bitv(9), '0);
    idle(2);

    // Async reset mid-cycle with backlog on lines 1 and 4.
    sel_v = 4'd1;
    pulse(bitv(1) | bitv(4), 3);
    idle(3);
    @(posedge clk_i);
    #3;
    rst_i     = 1'b1;
    event_i   = '0;
    irq_ret_i = '0;
    clr_i     = '0;
    #1;
    chk("async_rst_req", 32'(irq_req_o), 0);
    chk("async_rst_ovf", 32'(ovf_o), 0);
    chk("async_rst_cnt", 32'(cnt_o), 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Random phases, each opened with a full clear under a new mode mix.
    for (int p = 0; p < 3; p++) begin
      mode_v = irq_vec_t'($urandom);
      drive('0, '0, '1);
      for (int i = 0; i < 600; i++) begin
        irq_vec_t ev, rt, cl;
        ev = irq_vec_t'($urandom & $urandom);
        rt = irq_vec_t'($urandom & $urandom & $urandom);
        cl = ($urandom_range(0, 31) == 0) ? bitv($urandom_range(0, N - 1)) : '0;
        sel_v = 4'($urandom_range(0, N - 1));
        drive(ev, rt, cl);
      end
    end

    idle(1);
    repeat (3) @(posedge clk_i);
    #2;
    chk("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
